// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned magnitude comparator, MSB first, valid/ready on both sides.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first differing bit is seen.
module serial_mag_compare #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             l,
  output logic             e,
  output logic             g,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             l_q, l_d;
  logic             e_q, e_d;
  logic             g_q, g_d;
  logic             ai, bi;

  assign ai = a_q[WIDTH-1];
  assign bi = b_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    e_d     = e_q;
    g_d     = g_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = CW'(WIDTH);
          l_d     = 1'b0;
          e_d     = 1'b1;
          g_d     = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Once a difference is latched the lower bits can no longer change the verdict.
        if (!(l_q || g_q)) begin
          if (!ai && bi) begin
            l_d = 1'b1;
            e_d = 1'b0;
          end else if (ai && !bi) begin
            g_d = 1'b1;
            e_d = 1'b0;
          end
        end
        a_d   = a_q << 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (l_d || g_d) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      e_q     <= e_d;
      g_q     <= g_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign l         = l_q;
  assign e         = e_q;
  assign g         = g_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed bench for serial_mag_compare (WIDTH=8); expected latency follows the
// SERIAL_CMP_EARLY_EXIT_EN build option.
module tb_serial_mag_compare;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic       l, e, g;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_mag_compare #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .l        (l),
    .e        (e),
    .g        (g),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one pair from IDLE, then waits (bounded) for the result and checks it.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] lge, input int lat_ee, input bit keep_valid);
    int exp_lat;
    int n;
    exp_lat = EE ? lat_ee : 8;
    n = 0;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    if (keep_valid) begin
      a = ~av;
      b = ~bv;
    end else begin
      in_valid = 1'b0;
    end
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_lge"}, 32'({l, e, g}), 32'(lge));
    check({tag, "_nordy"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [7:0] pa [4] = '{8'hA7, 8'h3C, 8'h55, 8'h6E};
    logic [7:0] pb [4] = '{8'hA3, 8'hC3, 8'h55, 8'h6F};
    logic [2:0] pr [4] = '{GT, LT, EQ, LT};
    int         pl [4] = '{6, 1, 8, 8};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_lge", 32'({l, e, g}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_rdy", 32'(in_ready), 32'd1);

    // Equal operands with consumer always ready
    out_ready = 1'b1;
    run_op("eq", 8'h5A, 8'h5A, EQ, 8, 1'b0);
    step();
    check("eq_idle_ov", 32'(out_valid), 32'd0);
    check("eq_idle_lge", 32'({l, e, g}), 32'(EQ));

    run_op("msb", 8'h80, 8'h7F, GT, 1, 1'b0);
    step();
    check("msb_busy", 32'(busy), 32'd0);

    // Backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    run_op("lsb", 8'h03, 8'h04, LT, 6, 1'b0);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_lge", 32'({l, e, g}), 32'(LT));
      check("bp_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_rel_ov", 32'(out_valid), 32'd0);
    check("bp_rel_lge", 32'({l, e, g}), 32'(LT));
    run_op("bp_next", 8'hFF, 8'h00, GT, 1, 1'b0);
    step();

    // Reset on the third SHIFT cycle aborts the compare
    out_ready = 1'b1;
    check("mr_rdy", 32'(in_ready), 32'd1);
    a = 8'h01;
    b = 8'h02;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mr_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mr_rdy_in_rst", 32'(in_ready), 32'd0);
    step();
    check("mr_ov", 32'(out_valid), 32'd0);
    check("mr_lge", 32'({l, e, g}), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("mr_rdy_after", 32'(in_ready), 32'd1);
    run_op("mr_next", 8'h01, 8'h02, LT, 7, 1'b0);
    step();

    // Back-to-back stream with in_valid held high
    for (int k = 0; k < 4; k++) begin
      run_op($sformatf("b2b%0d", k), pa[k], pb[k], pr[k], pl[k], 1'b1);
      step();
      check($sformatf("b2b%0d_gap_ov", k), 32'(out_valid), 32'd0);
      check($sformatf("b2b%0d_gap_busy", k), 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
